div_seq_ctrl: RTL



---
 rtl/div_seq_ctrl_pkg.sv | 16 +
 rtl/div_seq_ctrl_if.sv | 25 ++
 rtl/div_seq_ctrl_step.sv | 30 +++
 rtl/div_seq_ctrl.sv | 131 +++++++++++++
 4 files changed

// File: rtl/div_seq_ctrl_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encodings,
// default operand width and the all-zero result constant.
package div_seq_ctrl_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam logic [2*DIV_WIDTH-1:0] DIV_RESULT_ZERO = '0;

endpackage

// File: rtl/div_seq_ctrl_if.sv
// Pipeline <-> divider handshake: request, operands, result and hold.
interface div_seq_ctrl_if #(
  parameter int WIDTH = div_seq_ctrl_pkg::DIV_WIDTH
);

  logic               start_i;
  logic               signed_i;
  logic               annul_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
  logic               stall_o;

  modport master (
    output start_i, signed_i, annul_i, opdata1_i, opdata2_i,
    input  result_o, ready_o, stall_o
  );

  modport slave (
    input  start_i, signed_i, annul_i, opdata1_i, opdata2_i,
    output result_o, ready_o, stall_o
  );

endinterface

// File: rtl/div_seq_ctrl_step.sv
// One radix-2 restoring iteration on unsigned magnitudes: shift {rem, quo}
// left by one, try to subtract the divisor, keep the difference if non-negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0]        shifted;
  logic signed [WIDTH:0] trial;

  // rem < divisor on entry, so shifted < 2*divisor and the true difference
  // always fits in WIDTH+1 signed bits; the modular subtraction is exact.
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    trial   = signed'(shifted - {1'b0, divisor});
    if (!trial[WIDTH]) begin
      rem_next = trial[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle DIV/DIVU unit for the EX stage: works on magnitudes, applies
// sign fix-up on completion and holds the pipeline while iterating.
module div_seq_ctrl
  import div_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  div_seq_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [2*WIDTH-1:0] RESULT_ZERO = (2*WIDTH)'(DIV_RESULT_ZERO);

  div_state_e         state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [WIDTH-1:0]   rem, rem_n, quo, quo_n, dvsr, dvsr_n;
  logic               neg_quo, neg_quo_n, neg_rem, neg_rem_n;
  logic [2*WIDTH-1:0] result, result_n;
  logic               ready, ready_n;
  logic [WIDTH-1:0]   step_rem, step_quo;

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] x, input logic en);
    return en ? (~x + 1'b1) : x;
  endfunction

  // The most negative value negates to itself and is then read as unsigned 2^(W-1).
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x, input logic sgn);
    return neg_if(x, sgn & x[WIDTH-1]);
  endfunction

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (dvsr),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    rem_n     = rem;
    quo_n     = quo;
    dvsr_n    = dvsr;
    neg_quo_n = neg_quo;
    neg_rem_n = neg_rem;
    result_n  = result;
    ready_n   = ready;
    unique case (state)
      DIV_FREE: begin
        result_n = RESULT_ZERO;
        ready_n  = 1'b0;
        if (bus.start_i && !bus.annul_i) begin
          if (bus.opdata2_i == '0) begin
            state_n = DIV_BYZERO;
          end else begin
            state_n   = DIV_ON;
            quo_n     = abs_val(bus.opdata1_i, bus.signed_i);
            dvsr_n    = abs_val(bus.opdata2_i, bus.signed_i);
            rem_n     = '0;
            cnt_n     = '0;
            neg_quo_n = bus.signed_i & (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
            neg_rem_n = bus.signed_i & bus.opdata1_i[WIDTH-1];
          end
        end
      end
      DIV_BYZERO: begin
        result_n = RESULT_ZERO;
        if (bus.annul_i) begin
          state_n = DIV_FREE;
          ready_n = 1'b0;
        end else begin
          state_n = DIV_END;
          ready_n = 1'b1;
        end
      end
      DIV_ON: begin
        if (bus.annul_i) begin
          state_n  = DIV_FREE;
          ready_n  = 1'b0;
          result_n = RESULT_ZERO;
        end else if (cnt == CNT_W'(WIDTH)) begin
          state_n  = DIV_END;
          ready_n  = 1'b1;
          result_n = {neg_if(rem, neg_rem), neg_if(quo, neg_quo)};
        end else begin
          rem_n = step_rem;
          quo_n = step_quo;
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DIV_END: begin
        if (!bus.start_i) begin
          state_n  = DIV_FREE;
          ready_n  = 1'b0;
          result_n = RESULT_ZERO;
        end
      end
      default: state_n = DIV_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= DIV_FREE;
      cnt    <= '0;
      result <= RESULT_ZERO;
      ready  <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      result <= result_n;
      ready  <= ready_n;
    end
  end

  always_ff @(posedge clk) begin
    rem     <= rem_n;
    quo     <= quo_n;
    dvsr    <= dvsr_n;
    neg_quo <= neg_quo_n;
    neg_rem <= neg_rem_n;
  end

  assign bus.result_o = result;
  assign bus.ready_o  = ready;
  assign bus.stall_o  = bus.start_i & ~ready & ~bus.annul_i;

endmodule
